// File: rtl/seg7_pkg.sv
// Shared ASCII constants and receive-state type for the UART character source.
// Build option: UART_CHAR_SOURCE_PARITY_EN adds the 8-E-1 parity state.
package seg7_pkg;

  localparam logic [7:0] CHAR_CR        = 8'h0D;
  localparam logic [7:0] CHAR_LF        = 8'h0A;
  localparam logic [7:0] CHAR_SPACE     = 8'h20;
  localparam logic [7:0] CHAR_MIN_PRINT = 8'h20;
  localparam logic [7:0] CHAR_MAX_PRINT = 8'h7E;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_CHAR_SOURCE_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_char_source_if.sv
// Serial input plus the character stream toward the 7-segment display.
// The master side is the UART character source.
interface uart_char_source_if;

  logic       rx;
  logic [7:0] char_out;
  logic       char_valid;
  logic       clear;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx,
    output char_out, char_valid, clear, frame_err, busy
  );

  modport slave (
    output rx,
    input  char_out, char_valid, clear, frame_err, busy
  );

endinterface

// File: rtl/rx_synchronizer.sv
// Two-flop synchroniser for the asynchronous serial line.
// Resets to the idle (high) level so no false start follows reset.
module rx_synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= 2'b11;
    else     ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/uart_char_source.sv
// UART receiver feeding filtered ASCII, clears and stretched valids to the display.
// Build option: UART_CHAR_SOURCE_PARITY_EN selects 8-E-1 framing.
module uart_char_source
  import seg7_pkg::*;
#(
  parameter int CLK_HZ       = 1_000_000,
  parameter int BAUD         = 9600,
  parameter int VALID_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  uart_char_source_if.master bus
);

  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int HALF    = BIT_DIV / 2;
  localparam int CW      = $clog2(BIT_DIV);
  localparam int VW      = $clog2(VALID_CYCLES + 1);

  localparam logic [CW-1:0] CNT_BIT  = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  logic          rx_s;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [VW-1:0] vcnt;
  logic [7:0]    char_q;
  logic          clear_q;
  logic          ferr_q;
  logic          tick;
  logic          frame_ok;
  logic          is_nl;
  logic          is_print;

  rx_synchronizer u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  assign tick     = (cnt == CNT_BIT);
  assign is_nl    = (shreg == CHAR_CR) || (shreg == CHAR_LF);
  assign is_print = (shreg >= CHAR_MIN_PRINT) && (shreg <= CHAR_MAX_PRINT);

`ifdef UART_CHAR_SOURCE_PARITY_EN
  logic par_bit;
  assign frame_ok = rx_s && !(^{shreg, par_bit});
`else
  assign frame_ok = rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      vcnt    <= '0;
      char_q  <= CHAR_SPACE;
      clear_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_CHAR_SOURCE_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      clear_q <= 1'b0;
      ferr_q  <= 1'b0;
      // Stretch runs free of the FSM; a load in STOP overrides this.
      if (vcnt != '0) vcnt <= vcnt - 1'b1;
      unique case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (tick) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_CHAR_SOURCE_PARITY_EN
              state <= RX_PARITY;
`else
              state <= RX_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_CHAR_SOURCE_PARITY_EN
        RX_PARITY: begin
          if (tick) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (tick) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (!frame_ok) begin
              ferr_q <= 1'b1;
            end else if (is_nl) begin
              clear_q <= 1'b1;
            end else if (is_print) begin
              char_q <= shreg;
              vcnt   <= VW'(VALID_CYCLES);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign bus.char_out   = char_q;
  assign bus.char_valid = (vcnt != '0);
  assign bus.clear      = clear_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_char_source.sv
// Directed bench for uart_char_source: frames, filtering, errors, resets.
// Define UART_CHAR_SOURCE_PARITY_EN to exercise 8-E-1 framing.
module tb_uart_char_source;

  localparam int BD = 104;

  logic clk = 1'b0;
  logic rst;

  uart_char_source_if bus ();

  uart_char_source dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #500 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int cyc_n = 0;
  int start_cyc;
  int n_rise, n_clear, n_ferr;
  int rise_cyc, ferr_cyc, bfall_cyc, brise_cyc;
  int vrun, last_vw, crun, max_crun, frun, max_frun;
  logic pv = 1'b0, pb = 1'b0;
  logic [7:0] chq[$];

  always @(negedge clk) begin
    cyc_n++;
    if (bus.char_valid) begin
      if (!pv) begin
        n_rise++;
        rise_cyc = cyc_n;
        chq.push_back(bus.char_out);
        vrun = 0;
      end
      vrun++;
      last_vw = vrun;
    end
    pv = bus.char_valid;
    if (bus.clear) begin
      if (crun == 0) n_clear++;
      crun++;
      if (crun > max_crun) max_crun = crun;
    end else crun = 0;
    if (bus.frame_err) begin
      if (frun == 0) begin n_ferr++; ferr_cyc = cyc_n; end
      frun++;
      if (frun > max_frun) max_frun = frun;
    end else frun = 0;
    if (bus.busy && !pb) brise_cyc = cyc_n;
    if (!bus.busy && pb) bfall_cyc = cyc_n;
    pb = bus.busy;
  end

  task automatic clr_mon();
    n_rise = 0; n_clear = 0; n_ferr = 0;
    rise_cyc = 0; ferr_cyc = 0; bfall_cyc = 0; brise_cyc = 0;
    vrun = 0; last_vw = 0; crun = 0; max_crun = 0;
    frun = 0; max_frun = 0;
    chq.delete();
  endtask

  task automatic drive_bit(input logic b, input int len);
    @(posedge clk);
    #1 bus.rx = b;
    repeat (len - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop,
                           input int stop_len, input logic bad_par);
    @(posedge clk);
    start_cyc = cyc_n;
    #1 bus.rx = 1'b0;
    repeat (BD - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BD);
`ifdef UART_CHAR_SOURCE_PARITY_EN
    drive_bit((^d) ^ bad_par, BD);
`else
    if (bad_par) drive_bit(1'b1, 1);
`endif
    drive_bit(stop, stop_len);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 bus.rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset();
    #1;
    nvec++; if (bus.char_out !== 8'h20) begin nerr++; $display("FAIL reset_char_out got %h want 20", bus.char_out); end
    nvec++; if (bus.char_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", bus.char_valid); end
    nvec++; if (bus.clear !== 1'b0) begin nerr++; $display("FAIL reset_clear got %b want 0", bus.clear); end
    nvec++; if (bus.frame_err !== 1'b0) begin nerr++; $display("FAIL reset_ferr got %b want 0", bus.frame_err); end
    nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_char_a();
    clr_mon();
    send_byte(8'h41, 1'b1, BD, 1'b0);
    idle(20);
    nvec++; if (n_rise !== 1) begin nerr++; $display("FAIL a_pulses got %0d want 1", n_rise); end
    nvec++; if (rise_cyc - start_cyc !== 992) begin nerr++; $display("FAIL a_valid_time got %0d want 992", rise_cyc - start_cyc); end
    nvec++; if (last_vw !== 4) begin nerr++; $display("FAIL a_valid_width got %0d want 4", last_vw); end
    nvec++; if (bus.char_out !== 8'h41) begin nerr++; $display("FAIL a_char_out got %h want 41", bus.char_out); end
    nvec++; if (n_clear + n_ferr !== 0) begin nerr++; $display("FAIL a_no_clear_err got %0d want 0", n_clear + n_ferr); end
    nvec++; if (brise_cyc - start_cyc !== 4) begin nerr++; $display("FAIL a_busy_rise got %0d want 4", brise_cyc - start_cyc); end
    nvec++; if (bfall_cyc - start_cyc !== 992) begin nerr++; $display("FAIL a_busy_fall got %0d want 992", bfall_cyc - start_cyc); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [6];
    msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D};
    clr_mon();
    foreach (msg[i]) send_byte(msg[i], 1'b1, BD, 1'b0);
    idle(20);
    nvec++; if (n_rise !== 5) begin nerr++; $display("FAIL hello_pulses got %0d want 5", n_rise); end
    for (int i = 0; i < 5 && i < chq.size(); i++) begin
      nvec++; if (chq[i] !== msg[i]) begin nerr++; $display("FAIL hello_char%0d got %h want %h", i, chq[i], msg[i]); end
    end
    nvec++; if (n_clear !== 1) begin nerr++; $display("FAIL hello_clear got %0d want 1", n_clear); end
    nvec++; if (max_crun !== 1) begin nerr++; $display("FAIL hello_clear_width got %0d want 1", max_crun); end
    nvec++; if (bus.char_out !== 8'h4F) begin nerr++; $display("FAIL hello_char_out got %h want 4f", bus.char_out); end
    nvec++; if (last_vw !== 4) begin nerr++; $display("FAIL hello_valid_width got %0d want 4", last_vw); end
  endtask

  task automatic test_false_start();
    clr_mon();
    drive_bit(1'b0, 30);
    idle(200);
    nvec++; if (n_rise + n_clear + n_ferr !== 0) begin nerr++; $display("FAIL false_start_pulses got %0d want 0", n_rise + n_clear + n_ferr); end
    nvec++; if (brise_cyc == 0 || bus.busy !== 1'b0) begin nerr++; $display("FAIL false_start_busy got rise=%0d busy=%b want rise>0 busy=0", brise_cyc, bus.busy); end
  endtask

  task automatic test_frame_err();
    clr_mon();
    send_byte(8'h35, 1'b0, BD, 1'b0);
    idle(200);
    nvec++; if (n_ferr !== 1) begin nerr++; $display("FAIL ferr_count got %0d want 1", n_ferr); end
    nvec++; if (max_frun !== 1) begin nerr++; $display("FAIL ferr_width got %0d want 1", max_frun); end
    nvec++; if (ferr_cyc - start_cyc !== 992) begin nerr++; $display("FAIL ferr_time got %0d want 992", ferr_cyc - start_cyc); end
    nvec++; if (n_rise !== 0) begin nerr++; $display("FAIL ferr_valid got %0d want 0", n_rise); end
    nvec++; if (bus.char_out !== 8'h4F) begin nerr++; $display("FAIL ferr_char_out got %h want 4f", bus.char_out); end
  endtask

  task automatic test_nonprint();
    clr_mon();
    send_byte(8'h07, 1'b1, BD, 1'b0);
    send_byte(8'h7F, 1'b1, BD, 1'b0);
    idle(20);
    nvec++; if (n_rise + n_clear + n_ferr !== 0) begin nerr++; $display("FAIL nonprint_pulses got %0d want 0", n_rise + n_clear + n_ferr); end
    nvec++; if (bus.char_out !== 8'h4F) begin nerr++; $display("FAIL nonprint_char_out got %h want 4f", bus.char_out); end
  endtask

  task automatic test_valid_cutoff();
    clr_mon();
    send_byte(8'h7E, 1'b1, 57, 1'b0);
    nvec++; if (bus.char_valid !== 1'b1) begin nerr++; $display("FAIL cutoff_pre got %b want 1", bus.char_valid); end
    #1 rst = 1'b1;
    #1;
    nvec++; if (bus.char_valid !== 1'b0) begin nerr++; $display("FAIL cutoff_valid got %b want 0", bus.char_valid); end
    idle(3);
    #1 rst = 1'b0;
    idle(10);
  endtask

  task automatic test_reset_mid();
    clr_mon();
    @(posedge clk);
    #1 bus.rx = 1'b0;
    repeat (BD - 1) @(posedge clk);
    for (int i = 0; i < 4; i++) drive_bit(1'b1 ^ i[0], BD);
    drive_bit(1'b1, 50);
    #1 rst = 1'b1;
    #1;
    nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL mid_busy got %b want 0", bus.busy); end
    idle(3);
    #1 rst = 1'b0;
    idle(1200);
    nvec++; if (n_rise + n_clear + n_ferr !== 0) begin nerr++; $display("FAIL mid_lost got %0d want 0", n_rise + n_clear + n_ferr); end
    nvec++; if (bus.char_out !== 8'h20) begin nerr++; $display("FAIL mid_char_out got %h want 20", bus.char_out); end
    send_byte(8'h39, 1'b1, BD, 1'b0);
    idle(20);
    nvec++; if (bus.char_out !== 8'h39) begin nerr++; $display("FAIL mid_after got %h want 39", bus.char_out); end
    nvec++; if (n_rise !== 1) begin nerr++; $display("FAIL mid_after_pulses got %0d want 1", n_rise); end
  endtask

`ifdef UART_CHAR_SOURCE_PARITY_EN
  task automatic test_parity();
    clr_mon();
    send_byte(8'h39, 1'b1, BD, 1'b1);
    idle(20);
    nvec++; if (n_ferr !== 1) begin nerr++; $display("FAIL parity_ferr got %0d want 1", n_ferr); end
    nvec++; if (n_rise !== 0) begin nerr++; $display("FAIL parity_valid got %0d want 0", n_rise); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.rx = 1'b1;
    clr_mon();
    repeat (3) @(posedge clk);
    test_reset();
    #1 rst = 1'b0;
    idle(10);
    test_reset();
    test_char_a();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_nonprint();
    test_valid_cutoff();
    test_reset_mid();
`ifdef UART_CHAR_SOURCE_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
